alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Operand-issue and writeback controller sitting directly upstream of the 8-bit registered ALU.
- Accepts commands over a valid/ready handshake.
- Reads operands from an internal 8x8 register file, or substitutes an immediate for B, and drives the ALU inputs.
- Captures the ALU result one clock later, writes it back to the register file, and reports completion with result flags.
- A host load/read port initialises and inspects registers.

Parameters:
NUM_REGS, 8, register-file depth (fixed at 8 for this design)
ADDR_W, 3, register address width (log2 NUM_REGS)
DATA_W, 8, datapath width; must equal the ALU width

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset (0 = reset)
CMD_VALID  in  1  command present
CMD_READY  out  1  block can accept a command
CMD_OP  in  4  ALU operation code
CMD_DST  in  3  destination register
CMD_SRCA  in  3  source register for A
CMD_SRCB  in  3  source register for B
CMD_IMM_EN  in  1  1 = use CMD_IMM as B instead of register SRCB
CMD_IMM  in  8  immediate operand
ALU_A  out  8  to ALU IN_A
ALU_B  out  8  to ALU IN_B
ALU_OP  out  4  to ALU ALU_OP
ALU_RESULT  in  8  from ALU OUT_RESULT
LOAD_EN  in  1  host register write strobe
LOAD_ADDR  in  3  host write address
LOAD_DATA  in  8  host write data
RD_ADDR  in  3  host read address
RD_DATA  out  8  combinational read of register RD_ADDR
BUSY  out  1  command in flight
DONE  out  1  one-cycle pulse, writeback completed
DONE_RESULT  out  8  value written back, held until next DONE
FLAG_ZERO  out  1  last written-back result == 0
FLAG_TRUE  out  1  bit 0 of last result when op was 9/A/B (compare), else 0

Behaviour:
Reset:
- Asserting RESET asynchronously forces state IDLE.
- All registers become 0. ALU_A, ALU_B, ALU_OP, DONE_RESULT, DONE, FLAG_ZERO and FLAG_TRUE become 0.
- BUSY=0, CMD_READY=1 after release.
- Reset mid-operation aborts the command with no writeback and no DONE.

Integration: the ALU reset (synchronous, active-high) is driven from the inverted RESET at top level.

FSM states: IDLE, EXEC, CAPT.
- IDLE: CMD_READY=1, BUSY=0. Accept on CMD_VALID & CMD_READY at cycle t.
  - ALU_A <= reg[SRCA].
  - ALU_B <= CMD_IMM_EN ? CMD_IMM : reg[SRCB].
  - ALU_OP <= CMD_OP. Latch DST and the compare-op indicator. Go to EXEC.
- EXEC (t+1): ALU inputs stable; ALU registers its result at the end of this cycle. Go to CAPT.
- CAPT (t+2): ALU_RESULT is valid. At the closing edge:
  - reg[DST] <= ALU_RESULT; DONE_RESULT <= ALU_RESULT.
  - FLAG_ZERO <= (ALU_RESULT==0).
  - FLAG_TRUE <= compare ? ALU_RESULT[0] : 0.
  - Pulse DONE; go to IDLE.
- t+3: DONE=1 and CMD_READY=1 together. A new command may be accepted in this cycle.
- Latency is accept to DONE = 3 cycles; maximum throughput is one command per 3 cycles.
- CMD_READY=0 and BUSY=1 in EXEC and CAPT. CMD_* inputs are ignored there.
- ALU_A, ALU_B and ALU_OP hold their last values while IDLE.

Operand forwarding: if LOAD_EN is high in the accept cycle and LOAD_ADDR matches SRCA (or SRCB with IMM_EN=0), LOAD_DATA is used as that operand.

Load port:
- LOAD_EN writes reg[LOAD_ADDR] at the clock edge in any state.
- If LOAD and writeback target the same register at the same edge, writeback wins and the load is dropped.
- Writes to different addresses at the same edge both complete.

RD_DATA is combinational. It shows the pre-edge value, so it has no write bypass.

Widths: all arithmetic is done by the ALU; this block performs no arithmetic. Opcodes C–F are passed through unchanged, and the ALU returns A for them.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_SHL=3, OP_SHR=4, OP_INCA=5, OP_INCB=6, OP_DECA=7, OP_DECB=8, OP_EQ=9, OP_GT=A, OP_LT=B;
  - the is_compare(op) helper;
  - the FSM state encoding.
- Sub-module alu_regfile: 8x8 flops, three combinational read ports (A, B, host), two write ports with writeback-over-load priority.

Test Plan:
- Load r1=0x05, r2=0x03; issue OP_ADD dst=r3 (A=r1, B=r2) at cycle t -> ALU_A=0x05, ALU_B=0x03 at t+1; DONE at t+3 with DONE_RESULT=0x08; RD_ADDR=3 reads 0x08; FLAG_ZERO=0.
- r1=0x05, imm 0x05, OP_SUB dst=r4 -> result 0x00, FLAG_ZERO=1; then OP_EQ with the same operands -> result 0x01, FLAG_TRUE=1.
- Back-to-back commands with CMD_VALID held high -> CMD_READY pattern 1,0,0,1; a second accept occurs in the same cycle as the first DONE; two DONE pulses 3 cycles apart.
- LOAD r2=0x7F in the same cycle as accepting OP_INCB (SRCB=r2) -> forwarded operand; result 0x80.
- LOAD r3=0xAA in the CAPT cycle of a writeback to r3 producing 0x11 -> r3=0x11; a LOAD to r5 in the same edge lands 0xAA.
- Assert RESET during EXEC -> DONE never pulses; all registers read 0; CMD_READY=1 the cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback controller: sizes,
// opcode map, FSM encoding and the compare-op classifier.
package alu_pkg;

  localparam int NUM_REGS = 8;  // register-file depth
  localparam int ADDR_W   = 3;  // log2(NUM_REGS)
  localparam int DATA_W   = 8;  // must match the ALU width
  localparam int OP_W     = 4;  // ALU opcode width

  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_MUL  = 4'h2;
  localparam logic [OP_W-1:0] OP_SHL  = 4'h3;
  localparam logic [OP_W-1:0] OP_SHR  = 4'h4;
  localparam logic [OP_W-1:0] OP_INCA = 4'h5;
  localparam logic [OP_W-1:0] OP_INCB = 4'h6;
  localparam logic [OP_W-1:0] OP_DECA = 4'h7;
  localparam logic [OP_W-1:0] OP_DECB = 4'h8;
  localparam logic [OP_W-1:0] OP_EQ   = 4'h9;
  localparam logic [OP_W-1:0] OP_GT   = 4'hA;
  localparam logic [OP_W-1:0] OP_LT   = 4'hB;

  // IDLE accepts, EXEC lets the ALU register, CAPT writes back.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CAPT = 2'd2
  } state_t;

  // Compare ops return a boolean in bit 0 that FLAG_TRUE reports.
  function automatic logic is_compare(input logic [OP_W-1:0] op);
    return (op == OP_EQ) || (op == OP_GT) || (op == OP_LT);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command channel (valid/ready plus operand selection) into the issue controller.
interface alu_issue_ctrl_if;
  import alu_pkg::*;

  logic              CMD_VALID;
  logic              CMD_READY;
  logic [OP_W-1:0]   CMD_OP;
  logic [ADDR_W-1:0] CMD_DST;
  logic [ADDR_W-1:0] CMD_SRCA;
  logic [ADDR_W-1:0] CMD_SRCB;
  logic              CMD_IMM_EN;
  logic [DATA_W-1:0] CMD_IMM;

  modport master (
    output CMD_VALID, CMD_OP, CMD_DST, CMD_SRCA, CMD_SRCB, CMD_IMM_EN, CMD_IMM,
    input  CMD_READY
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_DST, CMD_SRCA, CMD_SRCB, CMD_IMM_EN, CMD_IMM,
    output CMD_READY
  );

endinterface

// File: rtl/alu_regfile.sv
// 8x8 flop register file: three combinational read ports (A, B, host) and
// two write ports where the ALU writeback overrides a host load to the same entry.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] rd_a_addr,
  input  logic [ADDR_W-1:0] rd_b_addr,
  input  logic [ADDR_W-1:0] rd_h_addr,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  output logic [DATA_W-1:0] rd_h_data
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_all;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] reg_q;
      logic [DATA_W-1:0] reg_d;

      // Writeback has priority; a colliding load is simply dropped.
      always_comb begin
        reg_d = reg_q;
        if (wb_en && (wb_addr == ADDR_W'(gi))) begin
          reg_d = wb_data;
        end else if (ld_en && (ld_addr == ADDR_W'(gi))) begin
          reg_d = ld_data;
        end
      end

      // Register storage, cleared by reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) reg_q <= '0;
        else        reg_q <= reg_d;
      end

      assign regs_all[gi] = reg_q;
    end
  endgenerate

  // Reads show the pre-edge contents; no write bypass.
  assign rd_a_data = regs_all[rd_a_addr];
  assign rd_b_data = regs_all[rd_b_addr];
  assign rd_h_data = regs_all[rd_h_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Operand-issue and writeback controller for the 8-bit registered ALU.
// Accept -> EXEC -> CAPT -> writeback, DONE visible three cycles after accept.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  alu_issue_ctrl_if.slave   cmd,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [OP_W-1:0]   ALU_OP,
  input  logic [DATA_W-1:0] ALU_RESULT,
  input  logic              LOAD_EN,
  input  logic [ADDR_W-1:0] LOAD_ADDR,
  input  logic [DATA_W-1:0] LOAD_DATA,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] DONE_RESULT,
  output logic              FLAG_ZERO,
  output logic              FLAG_TRUE
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic              cmp_q, cmp_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] done_result_q, done_result_d;
  logic              flag_zero_q, flag_zero_d;
  logic              flag_true_q, flag_true_d;

  logic              cmd_ready;
  logic              busy;
  logic              accept;
  logic              wb_en;
  logic [DATA_W-1:0] rf_a, rf_b;
  logic [DATA_W-1:0] opnd_a, opnd_b;

  alu_regfile u_regfile (
    .clk       (CLK),
    .rst_n     (RESET),
    .wb_en     (wb_en),
    .wb_addr   (dst_q),
    .wb_data   (ALU_RESULT),
    .ld_en     (LOAD_EN),
    .ld_addr   (LOAD_ADDR),
    .ld_data   (LOAD_DATA),
    .rd_a_addr (cmd.CMD_SRCA),
    .rd_b_addr (cmd.CMD_SRCB),
    .rd_h_addr (RD_ADDR),
    .rd_a_data (rf_a),
    .rd_b_data (rf_b),
    .rd_h_data (RD_DATA)
  );

  assign accept = cmd.CMD_VALID && cmd_ready;
  assign wb_en  = (state_q == S_CAPT);

  // Operand selection, forwarding a same-cycle host load to the sources.
  always_comb begin
    opnd_a = (LOAD_EN && (LOAD_ADDR == cmd.CMD_SRCA)) ? LOAD_DATA : rf_a;
    if (cmd.CMD_IMM_EN)                            opnd_b = cmd.CMD_IMM;
    else if (LOAD_EN && (LOAD_ADDR == cmd.CMD_SRCB)) opnd_b = LOAD_DATA;
    else                                            opnd_b = rf_b;
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: fixed three-cycle walk once a command is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_CAPT;
      S_CAPT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: only IDLE accepts commands.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    if (state_q == S_IDLE) begin
      cmd_ready = 1'b1;
      busy      = 1'b0;
    end
  end

  // Datapath next values: latch operands on accept, capture result in CAPT.
  always_comb begin
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    dst_d         = dst_q;
    cmp_d         = cmp_q;
    done_d        = 1'b0;
    done_result_d = done_result_q;
    flag_zero_d   = flag_zero_q;
    flag_true_d   = flag_true_q;
    if (accept) begin
      alu_a_d  = opnd_a;
      alu_b_d  = opnd_b;
      alu_op_d = cmd.CMD_OP;
      dst_d    = cmd.CMD_DST;
      cmp_d    = is_compare(cmd.CMD_OP);
    end
    if (state_q == S_CAPT) begin
      done_d        = 1'b1;
      done_result_d = ALU_RESULT;
      flag_zero_d   = (ALU_RESULT == '0);
      flag_true_d   = cmp_q ? ALU_RESULT[0] : 1'b0;
    end
  end

  // Datapath registers; reset aborts any in-flight command.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      dst_q         <= '0;
      cmp_q         <= 1'b0;
      done_q        <= 1'b0;
      done_result_q <= '0;
      flag_zero_q   <= 1'b0;
      flag_true_q   <= 1'b0;
    end else begin
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      dst_q         <= dst_d;
      cmp_q         <= cmp_d;
      done_q        <= done_d;
      done_result_q <= done_result_d;
      flag_zero_q   <= flag_zero_d;
      flag_true_q   <= flag_true_d;
    end
  end

  assign cmd.CMD_READY = cmd_ready;
  assign BUSY          = busy;
  assign ALU_A         = alu_a_q;
  assign ALU_B         = alu_b_q;
  assign ALU_OP        = alu_op_q;
  assign DONE          = done_q;
  assign DONE_RESULT   = done_result_q;
  assign FLAG_ZERO     = flag_zero_q;
  assign FLAG_TRUE     = flag_true_q;

endmodule
